// File: rtl/pdu_io_gen.sv
// pdu_io_gen - peripheral/debug unit for the pipelined CPU.
//
// Turns the run/step buttons into a one-clock-wide CPU clock-enable, owns
// the memory-mapped IO registers (LED output, switch input with a
// valid/ready handshake and a sticky overflow flag, display register) and
// scans DIGITS hex digits of the display register onto an/seg.
//
// Optional feature: define PDU_DEBUG_VIEW_EN to add the register-file debug
// view (ports m_rf_addr / rf_data). With run stopped, a valid press loads
// m_rf_addr from the switches and the display scans rf_data.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   run, step, valid  board buttons/switches (registered once on entry)
//   in                switch data
//   cpu_en            CPU clock-enable
//   io_addr, io_dout, io_we   CPU IO bus write side
//   io_din            CPU IO bus read data (combinational)
//   out0              LED output register
//   ready, check      handshake status: ready = ~in_valid, check = {ovf, in_valid}
//   an, seg           digit select and hex nibble of the selected digit
//   m_rf_addr, rf_data  debug view (PDU_DEBUG_VIEW_EN only)
module pdu_io_gen #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 5,
  parameter int DIGITS = 8,
  parameter int SCAN_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      step,
  input  logic                      valid,
  input  logic [IN_W-1:0]           in,
  output logic                      cpu_en,
  input  logic [7:0]                io_addr,
  input  logic [DATA_W-1:0]         io_dout,
  input  logic                      io_we,
  output logic [DATA_W-1:0]         io_din,
  output logic [IN_W-1:0]           out0,
  output logic                      ready,
  output logic [1:0]                check,
  output logic [$clog2(DIGITS)-1:0] an,
  output logic [3:0]                seg
`ifdef PDU_DEBUG_VIEW_EN
  ,
  output logic [7:0]                m_rf_addr,
  input  logic [DATA_W-1:0]         rf_data
`endif
);

  localparam int DIG_W = $clog2(DIGITS);

  localparam logic [7:0] ADDR_OUT0   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_IN     = 8'h08;
  localparam logic [7:0] ADDR_DISP   = 8'h0C;
  localparam logic [7:0] ADDR_LIVE   = 8'h10;

  logic              run_s, step_s, valid_s;
  logic              step_q, valid_q;
  logic              step_p, valid_p;
  logic              wr, ack, hs_p, iv_ack;
  logic [IN_W-1:0]   in_reg;
  logic              in_valid, ovf;
  logic [DATA_W-1:0] disp, disp_src;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DIG_W-1:0]  dig;

  // ---- stage 0: input sampling and edge detection ----
  always_ff @(posedge clk) begin
    if (rst) begin
      run_s   <= 1'b0;
      step_s  <= 1'b0;
      valid_s <= 1'b0;
      step_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      run_s   <= run;
      step_s  <= step;
      valid_s <= valid;
      step_q  <= step_s;
      valid_q <= valid_s;
    end
  end

  assign step_p  = step_s & ~step_q;
  assign valid_p = valid_s & ~valid_q;

  // ---- stage 1: CPU enable, IO registers, handshake ----
  always_ff @(posedge clk) begin
    if (rst) cpu_en <= 1'b0;
    else     cpu_en <= run_s | step_p;
  end

  // Bus writes are only honoured in cycles where the CPU actually advances.
  assign wr  = io_we & cpu_en;
  assign ack = wr && (io_addr == ADDR_IN);

`ifdef PDU_DEBUG_VIEW_EN
  // With the CPU stopped the valid button selects the register to view
  // and leaves the input handshake alone.
  assign hs_p = valid_p & run_s;

  always_ff @(posedge clk) begin
    if (rst)                   m_rf_addr <= '0;
    else if (valid_p && !run_s) m_rf_addr <= 8'(in);
  end

  assign disp_src = run_s ? disp : rf_data;
`else
  assign hs_p     = valid_p;
  assign disp_src = disp;
`endif

  // The acknowledge is applied before a coincident new input is judged,
  // so ack + valid in one cycle accepts the new data instead of overflowing.
  assign iv_ack = in_valid & ~ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      out0     <= '0;
      disp     <= '0;
      in_reg   <= '0;
      in_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (wr && io_addr == ADDR_OUT0) out0 <= io_dout[IN_W-1:0];
      if (wr && io_addr == ADDR_DISP) disp <= io_dout;
      if (hs_p && !iv_ack) begin
        in_reg   <= in;
        in_valid <= 1'b1;
      end else begin
        in_valid <= iv_ack;
        if (hs_p) ovf <= 1'b1;
      end
    end
  end

  assign ready = ~in_valid;
  assign check = {ovf, in_valid};

  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_STATUS: io_din[1:0]      = {ovf, in_valid};
      ADDR_IN:     io_din[IN_W-1:0] = in_reg;
      ADDR_DISP:   io_din           = disp;
      ADDR_LIVE:   io_din[IN_W-1:0] = in;
      default:     io_din           = '0;
    endcase
  end

  // ---- stage 2: display scan ----
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      dig      <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
      if (&scan_cnt) begin
        if (dig == DIG_W'(DIGITS - 1)) dig <= '0;
        else                           dig <= dig + DIG_W'(1);
      end
    end
  end

  assign an = dig;

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig == DIG_W'(i)) seg = disp_src[4*i +: 4];
    end
  end

endmodule

// File: tb/tb_pdu_io_gen.sv
module tb_pdu_io_gen;

  localparam int DATA_W = 32;
  localparam int IN_W   = 5;
  localparam int DIGITS = 8;
  localparam int SCAN_W = 2;

  logic              clk = 1'b0;
  logic              rst, run, step, valid, io_we;
  logic [IN_W-1:0]   in;
  logic              cpu_en;
  logic [7:0]        io_addr;
  logic [DATA_W-1:0] io_dout, io_din;
  logic [IN_W-1:0]   out0;
  logic              ready;
  logic [1:0]        check;
  logic [2:0]        an;
  logic [3:0]        seg;

  int passed = 0;
  int total  = 0;

  pdu_io_gen #(.DATA_W(DATA_W), .IN_W(IN_W), .DIGITS(DIGITS), .SCAN_W(SCAN_W)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .valid(valid), .in(in),
    .cpu_en(cpu_en), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_din(io_din), .out0(out0), .ready(ready), .check(check), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    int pulses, first;
    logic [2:0] prev_an;
    bit synced;

    rst = 1; run = 0; step = 0; valid = 0; io_we = 0;
    in = '0; io_addr = 8'h04; io_dout = '0;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_check", 32'(check), 0);
    chk("rst_out0", 32'(out0), 0);
    chk("rst_an", 32'(an), 0);
    chk("rst_seg", 32'(seg), 0);
    chk("rst_status", io_din, 0);

    // Idle: no enable with run/step low
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_cpu_en", 32'(cpu_en), 0);
    end

    // Step held high: one pulse, visible after the second edge
    step = 1; pulses = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_en) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("step_pulses", 32'(pulses), 1);
    chk("step_latency", 32'(first), 2);
    step = 0;
    tick(); tick();

    // First input commit
    in = 5'h13; valid = 1;
    tick(); tick();
    io_addr = 8'h08; #1;
    chk("in1_ready", 32'(ready), 0);
    chk("in1_check", 32'(check), 2'b01);
    chk("in1_data", io_din, 32'h13);
    valid = 0; tick(); tick();

    // Second commit while pending: dropped, overflow set
    in = 5'h07; valid = 1;
    tick(); tick();
    chk("ovf_check", 32'(check), 2'b11);
    chk("ovf_data", io_din, 32'h13);
    valid = 0; tick(); tick();

    // Ack and new input in the same cycle
    run = 1; tick(); tick();
    chk("run_cpu_en", 32'(cpu_en), 1);
    in = 5'h0A; valid = 1;
    tick();
    io_we = 1; io_addr = 8'h08;
    tick();
    io_we = 0; valid = 0; #1;
    chk("ackv_check", 32'(check), 2'b11);
    chk("ackv_data", io_din, 32'h0A);
    tick();

    // Plain acknowledge clears in_valid, ovf stays
    io_we = 1; io_addr = 8'h08;
    tick();
    io_we = 0; #1;
    chk("ack_check", 32'(check), 2'b10);
    chk("ack_ready", 32'(ready), 1);

    // out0 write ignored while cpu_en is low
    run = 0; tick(); tick();
    chk("stop_cpu_en", 32'(cpu_en), 0);
    io_we = 1; io_addr = 8'h00; io_dout = 32'h0000001F;
    tick();
    io_we = 0; #1;
    chk("out0_blocked", 32'(out0), 0);
    run = 1; tick(); tick();
    io_we = 1; io_addr = 8'h00; io_dout = 32'h00ABCDE5;
    tick();
    io_we = 0; #1;
    chk("out0_write", 32'(out0), 5'h05);

    // Display register and scan
    io_we = 1; io_addr = 8'h0C; io_dout = 32'h12345678;
    tick();
    io_we = 0; #1;
    chk("disp_read", io_din, 32'h12345678);
    synced = 0;
    for (int i = 0; i < 64 && !synced; i++) begin
      prev_an = an;
      tick();
      if (prev_an == 3'd7 && an == 3'd0) synced = 1;
    end
    chk("scan_sync", 32'(synced), 1);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        chk("scan_an", 32'(an), 32'(d));
        chk("scan_seg", 32'(seg), 32'(8 - d));
        tick();
      end
    end
    chk("scan_wrap", 32'(an), 0);

    // Read mux: live input, status, unmapped
    in = 5'h15; io_addr = 8'h10; #1;
    chk("rd_live", io_din, 32'h15);
    io_addr = 8'h04; #1;
    chk("rd_status", io_din, 32'h2);
    io_addr = 8'h14; #1;
    chk("rd_unmapped", io_din, 0);

    // Reset during a step pulse with an input pending
    run = 0; tick(); tick();
    in = 5'h03; valid = 1;
    tick(); tick();
    chk("pend_check", 32'(check), 2'b11);
    valid = 0; step = 1;
    tick();
    rst = 1;
    tick();
    chk("mid_rst_cpu_en", 32'(cpu_en), 0);
    chk("mid_rst_check", 32'(check), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_out0", 32'(out0), 0);
    step = 0; rst = 0;
    tick();
    io_addr = 8'h0C; #1;
    chk("post_rst_cpu_en", 32'(cpu_en), 0);
    chk("post_rst_disp", io_din, 0);
    io_addr = 8'h08; #1;
    chk("post_rst_in_reg", io_din, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
